// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the run/step/halt sequencer: state encodings and
// default timing constants for the board clock.
package exec_ctrl_pkg;

    // Encodings are visible on the state output, so they are fixed values.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    // Free-run rate is clk / (DIV_MAX + 1); about 1 Hz on a 50 MHz board clock.
    localparam int DEF_DIV_MAX   = 49_999_999;
    // Button must be stable this many cycles (20 ms at 50 MHz).
    localparam int DEF_DB_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability-counter debounce and
// a one-cycle pulse on each debounced rising edge.
module btn_debounce
    import exec_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int             CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Synchronize, then let the debounced level follow only after the synced
    // input has disagreed with it for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/exec_ctrl.sv
// Run/step/halt sequencer: issues one-cycle cpu_en advances at a prescaled
// rate in RUN or one per step press, stops on halt request or PC breakpoint,
// and counts issued advances.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int DIV_MAX   = DEF_DIV_MAX,
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int PC_W      = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            run_sw,
    input  logic            step_btn,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    input  logic            halt_req,
    output logic            cpu_en,
    output logic [1:0]      state,
    output logic            halted,
    output logic [31:0]     cycle_cnt
);

    state_t      state_q;
    state_t      state_d;
    logic        cpu_en_q;
    logic        cpu_en_d;
    logic        skip_q;
    logic        skip_d;
    logic [31:0] div_q;
    logic [31:0] cycle_q;
    logic        run_s1;
    logic        run_s;
    logic        run_q;
    logic        step_pulse;
    logic        tick;
    logic        stop;
    logic        run_fall;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_step_db (
        .clk  (Clk),
        .rst_n(Reset),
        .btn  (step_btn),
        .pulse(step_pulse)
    );

    // Run switch synchronizer plus one delayed copy for falling-edge detect.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_s1 <= 1'b0;
            run_s  <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_s1 <= run_sw;
            run_s  <= run_s1;
            run_q  <= run_s;
        end
    end

    assign tick     = (state_q == RUN) && (div_q == 32'(DIV_MAX));
    // skip masks the breakpoint until the first instruction after a resume.
    assign stop     = halt_req | (bp_en & ~skip_q & (pc == bp_addr));
    assign run_fall = run_q & ~run_s;

    // Prescaler runs only in RUN and wraps on the tick edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_q <= '0;
        end else if (state_q != RUN || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 32'd1;
        end
    end

    // Next state, registered enable and breakpoint skip flag.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        skip_d   = skip_q;
        case (state_q)
            IDLE: begin
                if (run_s) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end else if (step_pulse && !halt_req) begin
                    state_d  = STEP;
                    cpu_en_d = 1'b1;
                end
            end
            RUN: begin
                if (!run_s) begin
                    state_d = IDLE;
                end else if (tick && stop) begin
                    state_d = HALT;
                end else if (tick) begin
                    cpu_en_d = 1'b1;
                    skip_d   = 1'b0;
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            HALT: begin
                if (step_pulse && !halt_req) begin
                    state_d  = STEP;
                    cpu_en_d = 1'b1;
                end else if (run_fall && !halt_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; cpu_en is registered so it is glitch-free.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cpu_en_q <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            skip_q   <= skip_d;
        end
    end

    // Count every issued advance, wrapping naturally at 32 bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_q <= '0;
        end else if (cpu_en_q) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign state     = state_q;
    assign halted    = (state_q == HALT);
    assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with DIV_MAX = 3 and DB_CYCLES = 4. A tiny
// datapath model advances pc by 4 on every observed cpu_en pulse.
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    localparam int DIV_MAX   = 3;
    localparam int DB_CYCLES = 4;
    localparam int PC_W      = 32;

    logic            Clk;
    logic            Reset;
    logic            run_sw;
    logic            step_btn;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic [PC_W-1:0] pc;
    logic            halt_req;
    logic            cpu_en;
    logic [1:0]      state;
    logic            halted;
    logic [31:0]     cycle_cnt;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   pulse_cnt;
    int   step_cycles;
    int   dbl_cnt;
    int   gap_bad;
    int   cyc;
    int   last_pulse_cyc;
    logic prev_en;
    bit   gap_chk;
    bit   drop_run_on_step;
    logic [1:0] last_state;
    logic [1:0] post_step_state;

    exec_ctrl #(
        .DIV_MAX  (DIV_MAX),
        .DB_CYCLES(DB_CYCLES),
        .PC_W     (PC_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .state    (state),
        .halted   (halted),
        .cycle_cnt(cycle_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge and update the datapath model.
    task automatic cycle();
        @(negedge Clk);
        cyc++;
        if (cpu_en === 1'b1) begin
            pulse_cnt++;
            pc = pc + 32'd4;
            if (prev_en === 1'b1) dbl_cnt++;
            if (gap_chk && last_pulse_cyc >= 0 && (cyc - last_pulse_cyc) != DIV_MAX + 1) gap_bad++;
            last_pulse_cyc = cyc;
        end
        if (state === 2'b10) begin
            step_cycles++;
            if (drop_run_on_step) run_sw = 1'b0;
        end
        if (last_state === 2'b10) post_step_state = state;
        prev_en    = cpu_en;
        last_state = state;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_counts();
        pulse_cnt      = 0;
        step_cycles    = 0;
        dbl_cnt        = 0;
        gap_bad        = 0;
        last_pulse_cyc = -1;
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        run_cycles(10);
        step_btn = 1'b0;
        run_cycles(10);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int i;
        i = 0;
        while (state !== s && i < budget) begin
            cycle();
            i++;
        end
        check(tag, {30'd0, state}, {30'd0, s});
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (pulse_cnt < n && i < budget) begin
            cycle();
            i++;
        end
        check(tag, pulse_cnt, n);
    endtask

    initial begin
        int i;
        Reset            = 1'b0;
        run_sw           = 1'b0;
        step_btn         = 1'b0;
        bp_en            = 1'b0;
        bp_addr          = '0;
        pc               = 32'h100;
        halt_req         = 1'b0;
        gap_chk          = 1'b0;
        drop_run_on_step = 1'b0;
        prev_en          = 1'b0;
        last_state       = 2'b00;
        post_step_state  = 2'b00;
        cyc              = 0;
        clear_counts();

        // Reset values
        run_cycles(3);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);

        // Release with run_sw high: RUN after 2 sync cycles + 1
        Reset  = 1'b1;
        run_sw = 1'b1;
        run_cycles(2);
        check("still_idle_2", {30'd0, state}, 32'd0);
        cycle();
        check("run_after_3", {30'd0, state}, 32'd1);

        // Free run: one pulse every 4 cycles, each one cycle wide
        clear_counts();
        gap_chk = 1'b1;
        run_cycles(41);
        gap_chk = 1'b0;
        check("free_pulses", pulse_cnt, 32'd10);
        check("free_cnt_eq", cycle_cnt, pulse_cnt);
        check("free_no_double", dbl_cnt, 32'd0);
        check("free_gap", gap_bad, 32'd0);

        // Reset in the middle of a pulse
        i = 0;
        while (cpu_en !== 1'b1 && i < 8) begin
            cycle();
            i++;
        end
        check("pulse_before_rst", {31'd0, cpu_en}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("async_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("async_state", {30'd0, state}, 32'd0);
        check("async_cycle_cnt", cycle_cnt, 32'd0);
        run_sw = 1'b0;
        run_cycles(2);
        Reset = 1'b1;
        run_cycles(4);
        check("idle_after_rst", {30'd0, state}, 32'd0);

        // Bouncy button: 1,0,1,0 glitches then held -> one step
        clear_counts();
        step_btn = 1'b1; cycle();
        step_btn = 1'b0; cycle();
        step_btn = 1'b1; cycle();
        step_btn = 1'b0; cycle();
        press_step();
        check("bounce_steps", step_cycles, 32'd1);
        check("bounce_pulses", pulse_cnt, 32'd1);
        check("bounce_cycle_cnt", cycle_cnt, 32'd1);
        check("bounce_post_step", {30'd0, post_step_state}, 32'd0);
        check("bounce_idle", {30'd0, state}, 32'd0);

        // Breakpoint at 0x10 from pc 0x08: two pulses then HALT
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        pc      = 32'h08;
        clear_counts();
        run_sw  = 1'b1;
        wait_state(2'b11, 40, "bp_halt");
        check("bp_halted", {31'd0, halted}, 32'd1);
        check("bp_pc", pc, 32'h10);
        check("bp_pulses", pulse_cnt, 32'd2);

        // Switch cycled: resume executes the instruction at the breakpoint
        run_sw = 1'b0;
        run_cycles(5);
        check("bp_fall_idle", {30'd0, state}, 32'd0);
        clear_counts();
        run_sw = 1'b1;
        wait_pulses(1, 20, "skip_pulse");
        run_sw = 1'b0;
        run_cycles(6);
        check("skip_pc", pc, 32'h14);
        check("skip_one_pulse", pulse_cnt, 32'd1);
        check("skip_idle", {30'd0, state}, 32'd0);

        // Back to the breakpoint, then a step out of HALT
        pc = 32'h0C;
        clear_counts();
        run_sw = 1'b1;
        wait_state(2'b11, 40, "bp_halt2");
        check("bp2_pulses", pulse_cnt, 32'd1);
        clear_counts();
        drop_run_on_step = 1'b1;
        press_step();
        drop_run_on_step = 1'b0;
        run_cycles(4);
        check("hstep_steps", step_cycles, 32'd1);
        check("hstep_pulses", pulse_cnt, 32'd1);
        check("hstep_post_state", {30'd0, post_step_state}, 32'd0);
        check("hstep_pc", pc, 32'h14);
        check("hstep_idle", {30'd0, state}, 32'd0);

        // halt_req in RUN: HALT on the next tick, steps ignored, sticky
        bp_en = 1'b0;
        clear_counts();
        run_sw = 1'b1;
        wait_state(2'b01, 6, "hreq_run");
        halt_req = 1'b1;
        wait_state(2'b11, 10, "hreq_halt");
        check("hreq_no_pulse", pulse_cnt, 32'd0);
        press_step();
        check("hreq_step_ignored", pulse_cnt, 32'd0);
        check("hreq_no_step", step_cycles, 32'd0);
        run_sw = 1'b0;
        run_cycles(5);
        check("hreq_sticky", {30'd0, state}, 32'd3);
        #2 Reset = 1'b0;
        #1;
        check("hreq_rst_state", {30'd0, state}, 32'd0);
        check("hreq_rst_halted", {31'd0, halted}, 32'd0);
        halt_req = 1'b0;
        cycle();
        Reset = 1'b1;
        run_cycles(3);

        // Counter wrap: preset to all ones, one step -> 0
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        clear_counts();
        press_step();
        check("wrap_pulse", pulse_cnt, 32'd1);
        check("wrap_cycle_cnt", cycle_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
